// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared constants and types for the sprite renderer:
//   - default sprite geometry, last visible column and transparent index
//   - rgb_t colour struct and the fixed 8-entry palette
// Optional feature macro used by the files that import this package:
//   SPRITE_MIRROR_EN (horizontal mirror with a frame-latched flip input)
// -----------------------------------------------------------------------------
package sprite_pkg;

  localparam int         SPR_W_DEFAULT      = 55;
  localparam int         SPR_H_DEFAULT      = 37;
  localparam int         H_LAST_DEFAULT     = 639;
  localparam logic [7:0] TRANSP_IDX_DEFAULT = 8'd7;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Entry 7 is the transparent index and never reaches the output.
  localparam rgb_t PALETTE [8] = '{
    24'h000000,  // 0 black
    24'hFFFFFF,  // 1 white
    24'h808080,  // 2 grey
    24'h808080,  // 3 grey
    24'hFFD800,  // 4 yellow
    24'hFF8000,  // 5 orange
    24'h808080,  // 6 grey
    24'h000000   // 7 unused (transparent)
  };

endpackage

// File: rtl/sprite_addr_gen.sv
// -----------------------------------------------------------------------------
// sprite_addr_gen
// Frame-latched sprite origin, in-box test and incremental ROM addressing
// (row_base + col, no multiplier). Produces a registered ROM address and a
// one-cycle-delayed valid bit for the palette stage.
// Ports:
//   Clk, Reset               pixel clock, async active-high reset
//   frame_start              latch origin (and flip) and restart counters
//   pixel_valid, DrawX/DrawY current scan position
//   pos_x, pos_y             requested origin, sampled only on frame_start
//   flip                     (SPRITE_MIRROR_EN only) horizontal mirror request
//   rom_addr                 registered sprite ROM address
//   v1                       rom_addr holds an in-sprite pixel this cycle
// Macro: SPRITE_MIRROR_EN adds the flip input and mirrored addressing.
// -----------------------------------------------------------------------------
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPR_W  = SPR_W_DEFAULT,
  parameter int SPR_H  = SPR_H_DEFAULT,
  parameter int H_LAST = H_LAST_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
`ifdef SPRITE_MIRROR_EN
  input  logic        flip,
`endif
  output logic [10:0] rom_addr,
  output logic        v1
);

  localparam int                COL_W    = $clog2(SPR_W);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SPR_W - 1);

  logic [9:0]       org_x_r;
  logic [9:0]       org_y_r;
  logic [10:0]      row_base_r;
  logic [COL_W-1:0] col_r;
  // Cleared by reset, set by frame_start: nothing draws from a stale origin.
  logic             armed_r;
`ifdef SPRITE_MIRROR_EN
  logic             flip_r;
`endif

  logic        in_x_s;
  logic        in_y_s;
  logic        draw_s;
  logic        row_end_s;
  logic [10:0] addr_s;

  // In-box compares widened to 11 bits so origin + size never wraps past 1023.
  always_comb begin
    in_x_s    = ({1'b0, DrawX} >= {1'b0, org_x_r}) &&
                ({1'b0, DrawX} <  ({1'b0, org_x_r} + 11'(SPR_W)));
    in_y_s    = ({1'b0, DrawY} >= {1'b0, org_y_r}) &&
                ({1'b0, DrawY} <  ({1'b0, org_y_r} + 11'(SPR_H)));
    draw_s    = pixel_valid && armed_r && in_x_s && in_y_s;
    row_end_s = pixel_valid && armed_r && in_y_s && (DrawX == 10'(H_LAST));
  end

  // Address for the current column, optionally mirrored within the row.
  always_comb begin
`ifdef SPRITE_MIRROR_EN
    if (flip_r) begin
      addr_s = row_base_r + (11'(SPR_W - 1) - 11'(col_r));
    end else begin
      addr_s = row_base_r + 11'(col_r);
    end
`else
    addr_s = row_base_r + 11'(col_r);
`endif
  end

  // Origin latch, row/column counters and the registered ROM address.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      org_x_r    <= 10'd0;
      org_y_r    <= 10'd0;
      row_base_r <= 11'd0;
      col_r      <= '0;
      armed_r    <= 1'b0;
      rom_addr   <= 11'd0;
      v1         <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      flip_r     <= 1'b0;
`endif
    end else begin
      if (draw_s) begin
        rom_addr <= addr_s;
        v1       <= 1'b1;
      end else begin
        v1       <= 1'b0;
      end

      // frame_start beats the row advance; the row advance beats the column step,
      // which also handles right-edge clipping where col never reaches SPR_W.
      if (frame_start) begin
        org_x_r    <= pos_x;
        org_y_r    <= pos_y;
        row_base_r <= 11'd0;
        col_r      <= '0;
        armed_r    <= 1'b1;
`ifdef SPRITE_MIRROR_EN
        flip_r     <= flip;
`endif
      end else if (row_end_s) begin
        row_base_r <= row_base_r + 11'(SPR_W);
        col_r      <= '0;
      end else if (draw_s && (col_r != COL_LAST)) begin
        col_r      <= col_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_renderer.sv
// -----------------------------------------------------------------------------
// sprite_renderer
// Raster-side sprite engine: addresses the sprite ROM (combinational read)
// and maps the returned palette index to RGB with a hit flag. Fixed 2-cycle
// latency from DrawX/DrawY to sprite_hit/Red/Green/Blue.
// Ports:
//   Clk, Reset               pixel clock, async active-high reset
//   frame_start              start-of-vblank pulse, latches pos_x/pos_y
//   pixel_valid, DrawX/DrawY scan position
//   pos_x, pos_y             requested sprite origin
//   flip                     (SPRITE_MIRROR_EN only) horizontal mirror
//   rom_addr / rom_data      sprite ROM address out, palette index in
//   sprite_hit               opaque sprite pixel present (registered)
//   Red, Green, Blue         palette colour, 0 when no hit (registered)
// Macro: SPRITE_MIRROR_EN enables the flip input and mirrored addressing.
// -----------------------------------------------------------------------------
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int         SPR_W      = SPR_W_DEFAULT,
  parameter int         SPR_H      = SPR_H_DEFAULT,
  parameter int         H_LAST     = H_LAST_DEFAULT,
  parameter logic [7:0] TRANSP_IDX = TRANSP_IDX_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
`ifdef SPRITE_MIRROR_EN
  input  logic        flip,
`endif
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        sprite_hit,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue
);

  logic v1_s;
  logic hit_s;
  rgb_t colour_s;

  sprite_addr_gen #(
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .H_LAST (H_LAST)
  ) u_addr_gen (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .pixel_valid (pixel_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
`ifdef SPRITE_MIRROR_EN
    .flip        (flip),
`endif
    .rom_addr    (rom_addr),
    .v1          (v1_s)
  );

  // Indices outside the 8-entry palette are treated as transparent.
  always_comb begin
    hit_s    = 1'b0;
    colour_s = rgb_t'(24'h000000);
    if (v1_s && (rom_data < 8'd8) && (rom_data != TRANSP_IDX)) begin
      hit_s    = 1'b1;
      colour_s = PALETTE[rom_data[2:0]];
    end else begin
      hit_s    = 1'b0;
      colour_s = rgb_t'(24'h000000);
    end
  end

  // Palette stage output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sprite_hit <= 1'b0;
      Red        <= 8'd0;
      Green      <= 8'd0;
      Blue       <= 8'd0;
    end else begin
      sprite_hit <= hit_s;
      Red        <= colour_s.r;
      Green      <= colour_s.g;
      Blue       <= colour_s.b;
    end
  end

endmodule
